l2cache_axi_bridge: RTL and testbench
=====================================

# l2cache_axi_bridge

Converts the L2 cache's line-granular memory port into AXI4 INCR bursts on a single 32-bit AXI master. Sits directly downstream of the L2 cache: serves line fills (read) and dirty-line write-backs (write) on independent read and write engines. The read engine holds back a fill that targets a line still being written back.

## Interface

Parameters:
- offset_width, 2: log2 of words per line; burst length = 1<<offset_width beats.
- LINE_W, 32*(1<<offset_width): line width in bits.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rstn  in  1  reset, asynchronous, active-low.
- addr_l2cache_mem_r  in  32  fill address, line-aligned.
- addr_l2cache_mem_w  in  32  write-back address, line-aligned.
- dout_l2cache_mem  in  LINE_W  write-back line; word 0 in bits [31:0].
- din_mem_l2cache  out  LINE_W  filled line.
- l2cache_mem_req_r  in  1  fill request.
- l2cache_mem_req_w  in  1  write-back request.
- l2cache_mem_rdy  in  1  L2 can accept a fill line this cycle.
- mem_l2cache_addrOK_r  out  1  fill request accepted.
- mem_l2cache_addrOK_w  out  1  write-back request accepted; address and line are sampled this edge.
- mem_l2cache_dataOK  out  1  fill line valid on din_mem_l2cache.
- AR channel: arvalid out 1, arready in 1, araddr out 32, arlen out 8, arsize out 3, arburst out 2.
- R channel: rvalid in 1, rready out 1, rdata in 32, rlast in 1, rresp in 2.
- AW channel: awvalid out 1, awready in 1, awaddr out 32, awlen out 8, awsize out 3, awburst out 2.
- W channel: wvalid out 1, wready in 1, wdata out 32, wstrb out 4, wlast out 1.
- B channel: bvalid in 1, bready out 1, bresp in 2.

## Operation

Fixed AXI fields:
- arlen and awlen are (1<<offset_width)-1.
- arsize and awsize are 3'b010.
- arburst and awburst are 2'b01.
- wstrb is 4'hF.

Read FSM (R_IDLE, R_AR, R_DATA, R_DONE):
- R_IDLE: mem_l2cache_addrOK_r = req_r && !hazard. When it is high, latch the address, clear the beat counter, go to R_AR.
- hazard = write FSM not idle && addr_r[31:offset_width+2] == latched write line address.
- R_AR: arvalid=1 until arready, then go to R_DATA.
- R_DATA: rready=1. Each rvalid stores rdata into word[cnt] and increments cnt. The beat with rlast, or the beat with cnt at its maximum, goes to R_DONE. rresp is ignored.
- R_DONE: mem_l2cache_dataOK = l2cache_mem_rdy. Go to R_IDLE on the cycle both are high.
- din_mem_l2cache holds the last filled line until the next fill overwrites it.

Write FSM (W_IDLE, W_AW, W_DATA, W_B):
- W_IDLE: mem_l2cache_addrOK_w = req_w. When it is high, latch the address and line, then go to W_AW.
- W_AW: awvalid=1 until awready, then go to W_DATA.
- W_DATA: wvalid=1, wdata = word[cnt], wlast when cnt is at its maximum. Each wready increments cnt. The last beat goes to W_B.
- W_B: bready=1. bvalid returns to W_IDLE.
- Write-backs are posted: no dataOK is given for a write.

Boundary conditions:
- Read and write requests in the same cycle: both are accepted independently. The hazard compares against the write address latched on an earlier edge, so a same-cycle pair is not blocked. The L2 never issues a fill of the line it is evicting, so this is safe.
- A valid output stays asserted until its handshake completes, even if the L2 request drops.
- rvalid arriving outside R_DATA is not possible, since rready=0 there.
- Reset mid-burst: both FSMs return to IDLE and all valid and ready outputs drop immediately. In-flight AXI transactions are abandoned; the system reset resets the slave as well.

## Timing

- Reset values: every output is 0 except the fixed AXI fields. din_mem_l2cache resets to 0.
- addrOK_r and addrOK_w are combinational from req and state, with zero-cycle accept.
- The earliest arvalid or awvalid is the cycle after accept.
- Fill latency with an always-ready slave and rdy=1: accept at cycle 0, AR at 1, beats at 2..N+1, dataOK at N+2 (N = beats).
- dataOK is a single-cycle pulse per fill.

## Structure

- Shared package (l2cache_pkg): AXI constants (BURST_INCR, SIZE_4B), the offset_width default, and the state encodings for the read and write FSMs.
- One natural sub-module, l2cache_axi_linebuf: a LINE_W register with a word-indexed write port and a word-indexed read mux. It is instantiated once for the read path and once for the write path.

## Test plan

- Single fill at 0x0000_1230: expect araddr=0x1230 and arlen=3. With rdata 0xA0..0xA3, din_mem_l2cache = {A3,A2,A1,A0} and a one-cycle dataOK at cycle 6.
- Write-back of 0x0000_4560 with line {D3..D0} and awready/wready stalled 2 cycles each: expect 4 beats, wlast on D3, wstrb=F, and return to idle only after bvalid.
- Fill at 0x4560 issued while that write-back is in W_DATA: addrOK_r stays 0 until the cycle after bvalid, then AR is issued.
- Fill with rdy=0 for 5 cycles after rlast: dataOK is withheld, then asserted exactly one cycle once rdy=1.
- Simultaneous req_r (0x1000) and req_w (0x2000): both addrOK are high in the same cycle, and AR and AW both go out the next cycle.
- rstn pulled low during beat 2 of a fill: all outputs reach reset values asynchronously. A fresh fill after release completes correctly.

Source files
------------

// File: rtl/l2cache_pkg.sv
// Shared definitions for the L2 cache to AXI4 bridge.
// Holds the fixed AXI burst fields, the default line geometry and the FSM state encodings.
package l2cache_pkg;

    localparam int          OFFSET_WIDTH_DEF = 2;

    localparam logic [1:0]  BURST_INCR = 2'b01;
    localparam logic [2:0]  SIZE_4B    = 3'b010;
    localparam logic [3:0]  STRB_ALL   = 4'hF;

    typedef enum logic [1:0] {
        R_IDLE,
        R_AR,
        R_DATA,
        R_DONE
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_AW,
        W_DATA,
        W_B
    } w_state_t;

endpackage

// File: rtl/l2cache_axi_linebuf.sv
// One cache line of storage: a whole-line load port, a word-indexed write port
// and a word-indexed read mux. Used as the fill buffer and the write-back buffer.
module l2cache_axi_linebuf
    import l2cache_pkg::*;
#(
    parameter int offset_width = OFFSET_WIDTH_DEF,
    parameter int LINE_W       = 32 * (1 << offset_width)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    load,
    input  logic [LINE_W-1:0]       load_line,
    input  logic                    wr_en,
    input  logic [offset_width-1:0] wr_idx,
    input  logic [31:0]             wr_word,
    input  logic [offset_width-1:0] rd_idx,
    output logic [31:0]             rd_word,
    output logic [LINE_W-1:0]       line
);

    // NOTE: this storage is reset on purpose: the fill buffer drives the L2's
    // data input directly, and that must read as zero out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            line <= '0;
        end else if (load) begin
            line <= load_line;
        end else if (wr_en) begin
            line[32*int'(wr_idx) +: 32] <= wr_word;
        end
    end

    assign rd_word = line[32*int'(rd_idx) +: 32];

endmodule

// File: rtl/l2cache_axi_bridge.sv
// Turns the L2's line fill / write-back port into AXI4 INCR bursts on one 32-bit master.
// Independent read and write engines; a fill of a line still being written back waits.
module l2cache_axi_bridge
    import l2cache_pkg::*;
#(
    parameter int offset_width = OFFSET_WIDTH_DEF,
    parameter int LINE_W       = 32 * (1 << offset_width)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [31:0]       addr_l2cache_mem_r,
    input  logic [31:0]       addr_l2cache_mem_w,
    input  logic [LINE_W-1:0] dout_l2cache_mem,
    output logic [LINE_W-1:0] din_mem_l2cache,
    input  logic              l2cache_mem_req_r,
    input  logic              l2cache_mem_req_w,
    input  logic              l2cache_mem_rdy,
    output logic              mem_l2cache_addrOK_r,
    output logic              mem_l2cache_addrOK_w,
    output logic              mem_l2cache_dataOK,
    output logic              arvalid,
    input  logic              arready,
    output logic [31:0]       araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    input  logic              rvalid,
    output logic              rready,
    input  logic [31:0]       rdata,
    input  logic              rlast,
    input  logic [1:0]        rresp,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              wvalid,
    input  logic              wready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    input  logic              bvalid,
    output logic              bready,
    input  logic [1:0]        bresp
);

    localparam int                      TAG_LO    = offset_width + 2;
    localparam logic [offset_width-1:0] CNT_MAX   = {offset_width{1'b1}};
    localparam logic [7:0]              BURST_LEN = 8'((1 << offset_width) - 1);

    r_state_t                r_state, r_state_nxt;
    w_state_t                w_state, w_state_nxt;
    logic [31:0]             r_addr_q, w_addr_q;
    logic [offset_width-1:0] r_cnt, w_cnt;
    logic                    hazard;
    logic                    r_word_wr;
    logic                    w_beat;

    logic [31:0]             fill_word_unused;
    logic [LINE_W-1:0]       wb_line_unused;
    logic                    resp_unused;

    assign arlen   = BURST_LEN;
    assign awlen   = BURST_LEN;
    assign arsize  = SIZE_4B;
    assign awsize  = SIZE_4B;
    assign arburst = BURST_INCR;
    assign awburst = BURST_INCR;
    assign wstrb   = STRB_ALL;

    assign araddr = r_addr_q;
    assign awaddr = w_addr_q;

    // Slave error responses are not reported back to the L2.
    assign resp_unused = ^{rresp, bresp};

    // Only a write-back latched on an earlier edge can block a fill, so a same-cycle pair both go.
    assign hazard = (w_state != W_IDLE) &&
                    (addr_l2cache_mem_r[31:TAG_LO] == w_addr_q[31:TAG_LO]);

    // NOTE: state and datapath registers use non-blocking assignments only,
    // so every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
        end else begin
            r_state <= r_state_nxt;
            w_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr_q <= '0;
            r_cnt    <= '0;
            w_addr_q <= '0;
            w_cnt    <= '0;
        end else begin
            if (mem_l2cache_addrOK_r) begin
                r_addr_q <= addr_l2cache_mem_r;
                r_cnt    <= '0;
            end else if (r_word_wr) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (mem_l2cache_addrOK_w) begin
                w_addr_q <= addr_l2cache_mem_w;
                w_cnt    <= '0;
            end else if (w_beat) begin
                w_cnt <= w_cnt + 1'b1;
            end
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        r_state_nxt          = r_state;
        mem_l2cache_addrOK_r = 1'b0;
        mem_l2cache_dataOK   = 1'b0;
        arvalid              = 1'b0;
        rready               = 1'b0;
        r_word_wr            = 1'b0;
        case (r_state)
            R_IDLE: begin
                mem_l2cache_addrOK_r = l2cache_mem_req_r && !hazard;
                if (mem_l2cache_addrOK_r) r_state_nxt = R_AR;
            end
            R_AR: begin
                arvalid = 1'b1;
                if (arready) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    r_word_wr = 1'b1;
                    if (rlast || (r_cnt == CNT_MAX)) r_state_nxt = R_DONE;
                end
            end
            R_DONE: begin
                mem_l2cache_dataOK = l2cache_mem_rdy;
                if (l2cache_mem_rdy) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_nxt          = w_state;
        mem_l2cache_addrOK_w = 1'b0;
        awvalid              = 1'b0;
        wvalid               = 1'b0;
        wlast                = 1'b0;
        bready               = 1'b0;
        w_beat               = 1'b0;
        case (w_state)
            W_IDLE: begin
                mem_l2cache_addrOK_w = l2cache_mem_req_w;
                if (l2cache_mem_req_w) w_state_nxt = W_AW;
            end
            W_AW: begin
                awvalid = 1'b1;
                if (awready) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                wvalid = 1'b1;
                wlast  = (w_cnt == CNT_MAX);
                w_beat = wready;
                if (wready && wlast) w_state_nxt = W_B;
            end
            W_B: begin
                bready = 1'b1;
                if (bvalid) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    l2cache_axi_linebuf #(
        .offset_width (offset_width),
        .LINE_W       (LINE_W)
    ) u_fill_buf (
        .clk       (clk),
        .rstn      (rstn),
        .load      (1'b0),
        .load_line ('0),
        .wr_en     (r_word_wr),
        .wr_idx    (r_cnt),
        .wr_word   (rdata),
        .rd_idx    (r_cnt),
        .rd_word   (fill_word_unused),
        .line      (din_mem_l2cache)
    );

    l2cache_axi_linebuf #(
        .offset_width (offset_width),
        .LINE_W       (LINE_W)
    ) u_wb_buf (
        .clk       (clk),
        .rstn      (rstn),
        .load      (mem_l2cache_addrOK_w),
        .load_line (dout_l2cache_mem),
        .wr_en     (1'b0),
        .wr_idx    ('0),
        .wr_word   ('0),
        .rd_idx    (w_cnt),
        .rd_word   (wdata),
        .line      (wb_line_unused)
    );

endmodule

// File: tb/tb_l2cache_axi_bridge.sv
// Self-checking bench for l2cache_axi_bridge: a transaction-level model of the L2 port
// checked every cycle, plus directed tests with hand-computed literal expectations.
module tb_l2cache_axi_bridge;

    localparam int OW    = 2;
    localparam int LW    = 32 * (1 << OW);
    localparam int BEATS = 1 << OW;

    logic          clk;
    logic          rstn;
    logic [31:0]   addr_l2cache_mem_r, addr_l2cache_mem_w;
    logic [LW-1:0] dout_l2cache_mem, din_mem_l2cache;
    logic          l2cache_mem_req_r, l2cache_mem_req_w, l2cache_mem_rdy;
    logic          mem_l2cache_addrOK_r, mem_l2cache_addrOK_w, mem_l2cache_dataOK;
    logic          arvalid, arready, rvalid, rready, rlast;
    logic [31:0]   araddr, rdata, awaddr, wdata;
    logic [7:0]    arlen, awlen;
    logic [2:0]    arsize, awsize;
    logic [1:0]    arburst, awburst, rresp, bresp;
    logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [3:0]    wstrb;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Slave knobs and negedge-sampled handshakes.
    logic [31:0] r_base = 32'h0;
    int          aw_stall = 0, w_stall = 0;
    bit          ar_fire, r_fire, aw_fire, w_fire, w_last_fire, b_fire;

    // Monitor records for directed checks.
    int          b_cyc = 0;
    int          wb_count = 0;
    logic [31:0] last_wdata = '0;

    l2cache_axi_bridge #(.offset_width(OW), .LINE_W(LW)) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .addr_l2cache_mem_r   (addr_l2cache_mem_r),
        .addr_l2cache_mem_w   (addr_l2cache_mem_w),
        .dout_l2cache_mem     (dout_l2cache_mem),
        .din_mem_l2cache      (din_mem_l2cache),
        .l2cache_mem_req_r    (l2cache_mem_req_r),
        .l2cache_mem_req_w    (l2cache_mem_req_w),
        .l2cache_mem_rdy      (l2cache_mem_rdy),
        .mem_l2cache_addrOK_r (mem_l2cache_addrOK_r),
        .mem_l2cache_addrOK_w (mem_l2cache_addrOK_w),
        .mem_l2cache_dataOK   (mem_l2cache_dataOK),
        .arvalid (arvalid), .arready (arready), .araddr (araddr), .arlen (arlen),
        .arsize  (arsize),  .arburst (arburst),
        .rvalid  (rvalid),  .rready  (rready),  .rdata  (rdata),  .rlast (rlast), .rresp (rresp),
        .awvalid (awvalid), .awready (awready), .awaddr (awaddr), .awlen (awlen),
        .awsize  (awsize),  .awburst (awburst),
        .wvalid  (wvalid),  .wready  (wready),  .wdata  (wdata),  .wstrb (wstrb), .wlast (wlast),
        .bvalid  (bvalid),  .bready  (bready),  .bresp  (bresp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [LW-1:0] got, input logic [LW-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic [LW-1:0] make_line(input logic [31:0] base);
        logic [LW-1:0] l;
        for (int i = 0; i < BEATS; i++) l[32*i +: 32] = base + 32'(i);
        return l;
    endfunction

    // AR/R slave: address always accepted at once, then BEATS back-to-back beats r_base+i.
    initial begin
        int r_left = 0;
        int r_idx  = 0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rlast = 1'b0; rresp = 2'b00;
        forever begin
            @(posedge clk); #1;
            if (!rstn) begin
                arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; r_left = 0; r_idx = 0;
            end else begin
                if (r_fire) begin r_idx++; r_left--; end
                if (ar_fire) begin r_left = BEATS; r_idx = 0; end
                arready = arvalid;
                rvalid  = (r_left > 0);
                rdata   = r_base + 32'(r_idx);
                rlast   = (r_left == 1);
            end
        end
    end

    // AW/W/B slave with per-handshake stall counts.
    initial begin
        int aw_cnt = 0;
        int w_cnt  = 0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        forever begin
            @(posedge clk); #1;
            if (!rstn) begin
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0; aw_cnt = 0; w_cnt = 0;
            end else begin
                if (aw_fire) begin awready = 1'b0; aw_cnt = 0; end
                else if (awvalid && !awready) begin
                    if (aw_cnt >= aw_stall) awready = 1'b1; else aw_cnt++;
                end
                if (w_fire) begin wready = 1'b0; w_cnt = 0; end
                else if (wvalid && !wready) begin
                    if (w_cnt >= w_stall) wready = 1'b1; else w_cnt++;
                end
                if (b_fire) bvalid = 1'b0;
                if (w_last_fire) bvalid = 1'b1;
            end
        end
    end

    // Transaction-level model of the L2-side contract, compared on every falling edge.
    initial begin
        bit            rd_busy = 0, ar_pend = 0, wr_busy = 0, aw_pend = 0;
        int            r_seen = 0, w_seen = 0;
        logic [31:0]   wr_line_addr = '0;
        logic [31:0]   exp_ar_q[$], exp_aw_q[$];
        logic [LW-1:0] exp_rline_q[$], exp_wline_q[$];
        logic [LW-1:0] wl;
        bit            exp_ok_r, exp_ok_w;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                check("rst_valids", LW'({mem_l2cache_addrOK_r, mem_l2cache_addrOK_w, mem_l2cache_dataOK,
                      arvalid, rready, awvalid, wvalid, wlast, bready}), '0);
                check("rst_din", din_mem_l2cache, '0);
                check("rst_addr", LW'({araddr, awaddr, wdata}), '0);
                {ar_fire, r_fire, aw_fire, w_fire, w_last_fire, b_fire} = '0;
                rd_busy = 0; ar_pend = 0; wr_busy = 0; aw_pend = 0;
                exp_ar_q.delete(); exp_aw_q.delete(); exp_rline_q.delete(); exp_wline_q.delete();
            end else begin
                ar_fire     = arvalid && arready;
                r_fire      = rvalid && rready;
                aw_fire     = awvalid && awready;
                w_fire      = wvalid && wready;
                w_last_fire = w_fire && wlast;
                b_fire      = bvalid && bready;

                exp_ok_r = l2cache_mem_req_r && !rd_busy &&
                           !(wr_busy && addr_l2cache_mem_r[31:OW+2] == wr_line_addr[31:OW+2]);
                exp_ok_w = l2cache_mem_req_w && !wr_busy;
                check("addrok_r", LW'(mem_l2cache_addrOK_r), LW'(exp_ok_r));
                check("addrok_w", LW'(mem_l2cache_addrOK_w), LW'(exp_ok_w));
                check("arvalid", LW'(arvalid), LW'(ar_pend));
                check("awvalid", LW'(awvalid), LW'(aw_pend));
                check("fixed_fields", LW'({arlen, awlen, arsize, awsize, arburst, awburst, wstrb}),
                      LW'({8'd3, 8'd3, 3'b010, 3'b010, 2'b01, 2'b01, 4'hF}));

                if (ar_fire) begin
                    if (exp_ar_q.size() == 0) check("ar_unexpected", 1, 0);
                    else check("araddr", LW'(araddr), LW'(exp_ar_q.pop_front()));
                    ar_pend = 0;
                end
                if (r_fire) r_seen++;
                if (mem_l2cache_dataOK) begin
                    check("dataok_rdy", LW'(l2cache_mem_rdy), 1);
                    check("dataok_after_burst", LW'({rd_busy, r_seen == BEATS}), LW'(2'b11));
                    if (exp_rline_q.size() == 0) check("fill_unexpected", 1, 0);
                    else check("fill_line", din_mem_l2cache, exp_rline_q.pop_front());
                    rd_busy = 0;
                end
                if (aw_fire) begin
                    if (exp_aw_q.size() == 0) check("aw_unexpected", 1, 0);
                    else check("awaddr", LW'(awaddr), LW'(exp_aw_q.pop_front()));
                    aw_pend  = 0;
                    wb_count = 0;
                end
                if (w_fire) begin
                    if (exp_wline_q.size() == 0) check("w_unexpected", 1, 0);
                    else begin
                        wl = exp_wline_q[0];
                        check("wdata", LW'(wdata), LW'(wl[32*(w_seen % BEATS) +: 32]));
                    end
                    check("wlast", LW'(wlast), LW'(w_seen == BEATS - 1));
                    w_seen++;
                    wb_count++;
                    if (wlast) last_wdata = wdata;
                end
                if (b_fire) begin
                    check("b_after_burst", LW'(w_seen), LW'(BEATS));
                    if (exp_wline_q.size() != 0) void'(exp_wline_q.pop_front());
                    wr_busy = 0;
                    b_cyc   = cyc;
                end

                if (exp_ok_r) begin
                    rd_busy = 1; ar_pend = 1; r_seen = 0;
                    exp_ar_q.push_back(addr_l2cache_mem_r);
                    exp_rline_q.push_back(make_line(r_base));
                end
                if (exp_ok_w) begin
                    wr_busy = 1; aw_pend = 1; w_seen = 0;
                    wr_line_addr = addr_l2cache_mem_w;
                    exp_aw_q.push_back(addr_l2cache_mem_w);
                    exp_wline_q.push_back(dout_l2cache_mem);
                end
            end
        end
    end

    // Called just after a rising edge; returns the cycle the request was accepted.
    task automatic do_fill(input logic [31:0] a, output int t_acc);
        bit got = 0;
        t_acc = -1;
        l2cache_mem_req_r  = 1'b1;
        addr_l2cache_mem_r = a;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_l2cache_addrOK_r) begin got = 1; t_acc = cyc; break; end
        end
        check("fill_accept_timeout", LW'(got), 1);
        @(posedge clk); #1;
        l2cache_mem_req_r = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [LW-1:0] l);
        bit got = 0;
        l2cache_mem_req_w  = 1'b1;
        addr_l2cache_mem_w = a;
        dout_l2cache_mem   = l;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_l2cache_addrOK_w) begin got = 1; break; end
        end
        check("wb_accept_timeout", LW'(got), 1);
        @(posedge clk); #1;
        l2cache_mem_req_w = 1'b0;
    endtask

    task automatic wait_dataok(input string name);
        bit got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_l2cache_dataOK) begin got = 1; break; end
        end
        check(name, LW'(got), 1);
    endtask

    initial begin
        int  t_acc, t_acc2, nb;
        bit  got;
        rstn = 1'b0;
        l2cache_mem_req_r = 1'b0; l2cache_mem_req_w = 1'b0; l2cache_mem_rdy = 1'b1;
        addr_l2cache_mem_r = '0; addr_l2cache_mem_w = '0; dout_l2cache_mem = '0;

        repeat (3) @(negedge clk);
        check("reset_arlen", LW'(arlen), LW'(8'd3));
        check("reset_wstrb", LW'(wstrb), LW'(4'hF));
        check("reset_din", din_mem_l2cache, '0);
        @(posedge clk); #2; rstn = 1'b1;
        @(posedge clk); #1;

        // Single fill at 0x1230.
        r_base = 32'hA0;
        do_fill(32'h0000_1230, t_acc);
        @(negedge clk);
        check("fill1_ar_next_cycle", LW'({arvalid, araddr, arlen}), LW'({1'b1, 32'h0000_1230, 8'd3}));
        wait_dataok("fill1_dataok_timeout");
        check("fill1_latency", LW'(cyc - t_acc), 6);
        check("fill1_line", din_mem_l2cache, 128'h000000A3_000000A2_000000A1_000000A0);
        @(negedge clk);
        check("fill1_pulse", LW'(mem_l2cache_dataOK), 0);
        check("fill1_hold", din_mem_l2cache, 128'h000000A3_000000A2_000000A1_000000A0);

        // Stalled write-back of 0x4560, then a fill of the same line during W_DATA.
        aw_stall = 2; w_stall = 2;
        @(posedge clk); #1;
        do_write(32'h0000_4560, make_line(32'hD000_0000));
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wvalid) begin got = 1; break; end
        end
        check("wb_wvalid_timeout", LW'(got), 1);
        @(posedge clk); #1;
        r_base = 32'h55;
        do_fill(32'h0000_4560, t_acc2);
        check("hazard_release", LW'(t_acc2 - b_cyc), 1);
        check("wb_beats", LW'(wb_count), LW'(BEATS));
        check("wb_last_word", LW'(last_wdata), LW'(32'hD000_0003));
        wait_dataok("hazard_fill_timeout");
        check("hazard_fill_line", din_mem_l2cache, 128'h00000058_00000057_00000056_00000055);

        // Fill with the L2 not ready for five cycles after the last beat.
        @(posedge clk); #1;
        l2cache_mem_rdy = 1'b0;
        r_base = 32'hB0;
        do_fill(32'h0000_3000, t_acc);
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rvalid && rready && rlast) begin got = 1; break; end
        end
        check("rdy0_rlast_timeout", LW'(got), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rdy0_withheld", LW'(mem_l2cache_dataOK), 0);
        end
        @(posedge clk); #1;
        l2cache_mem_rdy = 1'b1;
        @(negedge clk);
        check("rdy1_dataok", LW'(mem_l2cache_dataOK), 1);
        check("rdy1_line", din_mem_l2cache, 128'h000000B3_000000B2_000000B1_000000B0);
        @(negedge clk);
        check("rdy1_pulse", LW'(mem_l2cache_dataOK), 0);

        // Simultaneous fill and write-back.
        aw_stall = 0; w_stall = 0;
        r_base = 32'h10;
        @(posedge clk); #1;
        l2cache_mem_req_r = 1'b1; addr_l2cache_mem_r = 32'h0000_1000;
        l2cache_mem_req_w = 1'b1; addr_l2cache_mem_w = 32'h0000_2000;
        dout_l2cache_mem  = make_line(32'h20);
        @(negedge clk);
        check("simul_addrok", LW'({mem_l2cache_addrOK_r, mem_l2cache_addrOK_w}), LW'(2'b11));
        @(posedge clk); #1;
        l2cache_mem_req_r = 1'b0; l2cache_mem_req_w = 1'b0;
        @(negedge clk);
        check("simul_ar_aw", LW'({arvalid, awvalid}), LW'(2'b11));
        wait_dataok("simul_dataok_timeout");
        check("simul_line", din_mem_l2cache, 128'h00000013_00000012_00000011_00000010);
        repeat (20) @(negedge clk);

        // Reset during the second beat of a fill, then a fresh fill.
        @(posedge clk); #1;
        r_base = 32'hC0;
        do_fill(32'h0000_5000, t_acc);
        nb = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rvalid && rready) nb++;
            if (nb == 2) break;
        end
        check("midrst_beat2_timeout", LW'(nb), 2);
        #1 rstn = 1'b0;
        #1;
        check("midrst_outputs", LW'({rready, arvalid, mem_l2cache_dataOK, mem_l2cache_addrOK_r,
              awvalid, wvalid, bready}), '0);
        check("midrst_din", din_mem_l2cache, '0);
        repeat (2) @(negedge clk);
        @(posedge clk); #2; rstn = 1'b1;
        @(posedge clk); #1;
        r_base = 32'hE0;
        do_fill(32'h0000_6000, t_acc);
        wait_dataok("postrst_dataok_timeout");
        check("postrst_line", din_mem_l2cache, 128'h000000E3_000000E2_000000E1_000000E0);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
